decode_stage: RTL
=================

# decode_stage

Instruction decode / operand-fetch stage of the pipelined MIPS core.
- Accepts one instruction word per cycle over a valid/ready handshake.
- Drives the register-file read addresses and bypasses a same-cycle writeback.
- Decodes control fields and detects load-use hazards.
- Registers the result into the ID/EX pipeline register consumed by the execute stage.

## Interface
- DATA_W, 32, datapath width
- ADDR_W, 5, register address width
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- instr_valid  in  1  fetch offers instr
- instr  in  32  MIPS instruction word
- pc_plus4  in  DATA_W  PC+4 of instr
- instr_ready  out  1  stage accepts instr this cycle
- raA, raB  out  ADDR_W  register-file read addresses (rs, rt); combinational from instr
- rdA, rdB  in  DATA_W  register-file read data (combinational)
- wb_wen, wb_wa, wb_wd  in  1/ADDR_W/DATA_W  writeback port (same signals drive the register file)
- flush  in  1  taken branch: discard everything in this stage
- ex_valid  out  1  ID/EX holds a valid entry
- ex_ready  in  1  execute consumes the entry
- ex_opA, ex_opB, ex_imm, ex_pc4  out  DATA_W  operands, sign-extended immediate, PC+4
- ex_dst  out  ADDR_W  destination register
- ex_alu_op  out  4  ALU operation
- ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal  out  1 each  control bits

## Operation
- **Fields:** op = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0]. ex_imm = sign-extended instr[15:0].
- **Decode:**
  - op 0x00 R-type: funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT; dst = rd; reg_write = 1.
  - 0x08 addi: ADD, alu_src = 1, dst = rt, reg_write = 1.
  - 0x23 lw: ADD, alu_src = 1, mem_read = 1, dst = rt, reg_write = 1.
  - 0x2B sw: ADD, alu_src = 1, mem_write = 1.
  - 0x04 beq: SUB, branch = 1.
  - Any other op/funct: all controls 0, ex_illegal = 1; the entry still flows.
- **ALU codes:** AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
- **R0 handling:** reg_write is forced to 0 when dst = 0.
- **Bypass:** if wb_wen and wb_wa == raA and wb_wa != 0, opA = wb_wd; otherwise rdA. Same rule for B.
- **Load-use hazard:** hazard = ex_valid & ex_mem_read & ex_dst != 0 & (ex_dst == rs | (ex_dst == rt & op uses rt)). "op uses rt" is true for R-type, sw and beq.
- **Handshake:**
  - advance = ~ex_valid | ex_ready.
  - instr_ready = advance & ~hazard & ~flush.
  - Transfer happens when instr_valid & instr_ready.
- **ID/EX update priority (per edge):**
  1. reset: all ex_* = 0.
  2. flush: ex_valid = 0, other fields don't-care.
  3. advance & hazard: bubble, ex_valid = 0; the fetch holds instr.
  4. transfer: load the decoded entry, ex_valid = 1.
  5. advance without transfer: ex_valid = 0.
  6. Otherwise: hold all ex_* unchanged.

## Timing
- Latency: 1 cycle from transfer to ex_* valid.
- raA/raB and instr_ready are combinational. ex_* are registered only.
- Load-use stall is exactly 1 cycle. The bubble clears the hazard on the next cycle.
- While ex_valid & ~ex_ready, ex_* are stable and instr_ready = 0.
- Reset mid-stall or mid-transfer: every output is 0 on the next edge. instr_ready follows the combinational rule: 1 when ~flush and no hazard.
- A flush coinciding with instr_valid: the instruction is not accepted (instr_ready = 0).

## Structure
- **Package mips_pkg:** opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ), funct constants, ALU code constants, and an ID/EX entry struct typedef.
- **Sub-module main_ctrl_decoder:** purely combinational, {op, funct} to control bits, alu_op and illegal.
- **Top-level block:** bypass muxes, hazard logic and the ID/EX register stay in decode_stage.

## Test plan
- **R-type decode:** regs preloaded with R[i] = i; instr 0x00221820 (add r3, r1, r2), ex_ready = 1. Next cycle: ex_valid = 1, opA = 1, opB = 2, dst = 3, alu_op = 0010, reg_write = 1.
- **Bypass:** wb_wen = 1, wb_wa = 1, wb_wd = 0xAA in the same cycle as add r3, r1, r2. Required: opA = 0xAA. Repeat with wb_wa = 0: opA = R[0] = 0, no bypass.
- **Load-use:** lw r5, 4(r0) followed by add r6, r5, r1. Required: one cycle with instr_ready = 0 and ex_valid = 0 after the lw, then add issues. Repeat with sw r5 using r5 only as rt: also stalls.
- **Backpressure:** ex_ready = 0 for 3 cycles. Required: ex_* held constant, instr_ready = 0, no instruction lost or duplicated.
- **Flush:** flush = 1 while instr_valid = 1. Required: next cycle ex_valid = 0 and the offered instruction is not accepted. Synchronous reset during backpressure: all ex_* = 0 on the next edge.
- **Illegal/R0:** op 0x3F gives ex_illegal = 1 with all controls 0. addi r0, r1, 5 gives reg_write = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: MIPS opcode, funct and ALU constants plus the ID/EX entry type
package mips_pkg;
  localparam int XLEN = 32;
  localparam int RLEN = 5;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc4;
    logic [RLEN-1:0] dst;
    logic [3:0]      alu_op;
    logic            alu_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            illegal;
  } id_ex_t;
endpackage

// File: rtl/main_ctrl_decoder.sv
// main_ctrl_decoder: combinational {op, funct} to control bits, alu_op and illegal flag
module main_ctrl_decoder
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       alu_src,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       branch,
  output logic       illegal,
  output logic       dst_rd,
  output logic       uses_rt
);
  logic rtype, r_ok, imm_add;
  always_comb begin
    rtype = op == OP_RTYPE;
    r_ok = rtype && (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
    imm_add = op inside {OP_ADDI, OP_LW, OP_SW};
    illegal = !(r_ok || imm_add || op == OP_BEQ);
    alu_op = r_ok ? (funct == FN_SUB ? ALU_SUB : funct == FN_AND ? ALU_AND :
                     funct == FN_OR ? ALU_OR : funct == FN_SLT ? ALU_SLT : ALU_ADD) :
             imm_add ? ALU_ADD : op == OP_BEQ ? ALU_SUB : ALU_AND;
    alu_src = imm_add;
    reg_write = r_ok || op == OP_ADDI || op == OP_LW;
    mem_read = op == OP_LW;
    mem_write = op == OP_SW;
    branch = op == OP_BEQ;
    dst_rd = rtype;
    uses_rt = rtype || op == OP_SW || op == OP_BEQ;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage with writeback bypass, load-use stall and ID/EX register
module decode_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_plus4,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] raA,
  output logic [ADDR_W-1:0] raB,
  input  logic [DATA_W-1:0] rdA,
  input  logic [DATA_W-1:0] rdB,
  input  logic              wb_wen,
  input  logic [ADDR_W-1:0] wb_wa,
  input  logic [DATA_W-1:0] wb_wd,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_opA,
  output logic [DATA_W-1:0] ex_opB,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [ADDR_W-1:0] ex_dst,
  output logic [3:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_illegal
);
  logic [ADDR_W-1:0] rs, rt, rd;
  logic [3:0] alu_op;
  logic alu_src, reg_write, mem_read, mem_write, branch, illegal, dst_rd, uses_rt;
  logic hazard, advance, unused;
  id_ex_t ex_q, ex_d;
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign raA = rs;
  assign raB = rt;
  assign unused = ^instr[10:6];
  main_ctrl_decoder u_dec (
    .op(instr[31:26]),
    .funct(instr[5:0]),
    .alu_op(alu_op),
    .alu_src(alu_src),
    .reg_write(reg_write),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .branch(branch),
    .illegal(illegal),
    .dst_rd(dst_rd),
    .uses_rt(uses_rt)
  );
  always_comb begin
    hazard = ex_q.valid && ex_q.mem_read && ex_q.dst != '0 &&
             (ex_q.dst == rs || (ex_q.dst == rt && uses_rt));
    advance = !ex_q.valid || ex_ready;
    instr_ready = advance && !hazard && !flush;
    ex_d.valid = 1'b1;
    ex_d.opa = (wb_wen && wb_wa == rs && wb_wa != '0) ? wb_wd : rdA;
    ex_d.opb = (wb_wen && wb_wa == rt && wb_wa != '0) ? wb_wd : rdB;
    ex_d.imm = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    ex_d.pc4 = pc_plus4;
    ex_d.dst = !reg_write ? '0 : dst_rd ? rd : rt;
    ex_d.alu_op = alu_op;
    ex_d.alu_src = alu_src;
    ex_d.reg_write = reg_write && ex_d.dst != '0;
    ex_d.mem_read = mem_read;
    ex_d.mem_write = mem_write;
    ex_d.branch = branch;
    ex_d.illegal = illegal;
  end
  // instr_ready already excludes flush and hazard, so any non-transfer advance drains to a bubble
  always_ff @(posedge clock)
    if (reset) ex_q <= '0;
    else if (instr_valid && instr_ready) ex_q <= ex_d;
    else if (flush || advance) ex_q.valid <= 1'b0;
  assign ex_valid = ex_q.valid;
  assign ex_opA = ex_q.opa;
  assign ex_opB = ex_q.opb;
  assign ex_imm = ex_q.imm;
  assign ex_pc4 = ex_q.pc4;
  assign ex_dst = ex_q.dst;
  assign ex_alu_op = ex_q.alu_op;
  assign ex_alu_src = ex_q.alu_src;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_branch = ex_q.branch;
  assign ex_illegal = ex_q.illegal;
endmodule
